// File: rtl/tmax_scan_ctrl.sv
// Scan controller: streams samples into a per-channel max tracker, slots in clears and reads.
// Optional drop counter enabled by defining TMAX_SCAN_DROP_CNT_EN.
module tmax_scan_ctrl #(
  parameter int WIDTH  = 19,
  parameter int STARVE = 4
) (
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic [9:0]     T_IN,
  input  logic [4:0]     T_CH,
  input  logic           T_VALID,
  output logic           T_READY,
  input  logic           RUN,
  input  logic [WIDTH:0] CH_MASK,
  input  logic           CLR_REQ,
  input  logic [WIDTH:0] CLR_MASK,
  output logic           CLR_ACK,
  input  logic           RD_REQ,
  input  logic [4:0]     RD_CH,
  output logic           RD_ACK,
  output logic [9:0]     RD_DATA,
  output logic [9:0]     TM_T,
  output logic [4:0]     TM_NUMBER,
  output logic           TM_EN,
  output logic [WIDTH:0] TM_EN_CPU,
  output logic           TM_RESET,
  input  logic [9:0]     TM_TOUT,
  output logic           BUSY,
  output logic [15:0]    DROP_CNT
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_CLR    = 2'd2;
  localparam logic [1:0] S_RD     = 2'd3;

  localparam logic [4:0] MAX_CH = 5'(WIDTH);
  localparam logic [7:0] STV    = 8'(STARVE);

  logic [1:0]     state, state_nx;
  logic           upd_q, acc_q;
  logic [4:0]     upd_ch, acc_ch;
  logic           clr_hold, rd_hold;
  logic           clr_ack_q, rd_ack_q;
  logic [9:0]     rd_data_q;
  logic [7:0]     stv_cnt;
  logic [31:0]    mask_ext;
  logic [WIDTH:0] upd_oh;
  logic           in_rng, trk, acc, trk_acc;
  logic           clr_pend, rd_pend, hazard, starved;

  assign mask_ext = 32'(CH_MASK);
  assign in_rng   = T_CH <= MAX_CH;
  assign trk      = in_rng && mask_ext[T_CH];
  assign hazard   = acc_q && (T_CH == acc_ch);
  assign starved  = stv_cnt >= STV;
  assign T_READY  = (state == S_STREAM) && RUN
                    && !hazard && !starved;
  assign acc      = T_VALID && T_READY;
  assign trk_acc  = acc && trk;
  assign clr_pend = CLR_REQ && !clr_hold;
  assign rd_pend  = RD_REQ && !rd_hold;
  assign upd_oh   = {{WIDTH{1'b0}}, 1'b1} << upd_ch;

  // Next state: clear/read only go when the next cycle carries no update.
  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        if (clr_pend)     state_nx = S_CLR;
        else if (rd_pend) state_nx = S_RD;
        else if (RUN)     state_nx = S_STREAM;
      end
      S_STREAM: begin
        if (clr_pend) begin
          if (!trk_acc) state_nx = S_CLR;
        end else if (rd_pend) begin
          if (!trk_acc) state_nx = S_RD;
        end else if (!RUN) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = RUN ? S_STREAM : S_IDLE;
    endcase
  end

  // Tracker drive for accept cycle, update phase, clear and read.
  always_comb begin
    TM_T      = trk_acc ? T_IN : 10'd0;
    TM_EN     = trk_acc;
    TM_RESET  = state == S_CLR;
    TM_NUMBER = 5'd0;
    TM_EN_CPU = '0;
    if (trk_acc)
      TM_NUMBER = T_CH + 5'd1;
    else if (state == S_RD)
      TM_NUMBER = RD_CH + 5'd1;
    if (state == S_CLR)
      TM_EN_CPU = CLR_MASK;
    else if (upd_q)
      TM_EN_CPU = upd_oh;
  end

  // State, update phase, hazard tracking, request bookkeeping.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= S_IDLE;
      upd_q     <= 1'b0;
      upd_ch    <= 5'd0;
      acc_q     <= 1'b0;
      acc_ch    <= 5'd0;
      clr_hold  <= 1'b0;
      rd_hold   <= 1'b0;
      clr_ack_q <= 1'b0;
      rd_ack_q  <= 1'b0;
      rd_data_q <= 10'd0;
      stv_cnt   <= 8'd0;
    end else begin
      state     <= state_nx;
      upd_q     <= trk_acc;
      upd_ch    <= T_CH;
      acc_q     <= acc;
      acc_ch    <= T_CH;
      clr_ack_q <= state == S_CLR;
      rd_ack_q  <= state == S_RD;
      if (state == S_CLR)  clr_hold <= 1'b1;
      else if (!CLR_REQ)   clr_hold <= 1'b0;
      if (state == S_RD)   rd_hold <= 1'b1;
      else if (!RD_REQ)    rd_hold <= 1'b0;
      if (state == S_RD)
        rd_data_q <= (RD_CH <= MAX_CH) ? TM_TOUT : 10'd0;
      if ((state == S_STREAM) && (clr_pend || rd_pend)) begin
        if (!starved) stv_cnt <= stv_cnt + 8'd1;
      end else begin
        stv_cnt <= 8'd0;
      end
    end
  end

  assign CLR_ACK = clr_ack_q;
  assign RD_ACK  = rd_ack_q;
  assign RD_DATA = rd_data_q;
  assign BUSY    = upd_q || (state == S_CLR) || (state == S_RD)
                   || clr_pend || rd_pend;

`ifdef TMAX_SCAN_DROP_CNT_EN
  logic [15:0] drop_q;

  // Saturating count of consumed but untracked samples.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      drop_q <= 16'd0;
    else if (acc && !trk && (drop_q != 16'hFFFF))
      drop_q <= drop_q + 16'd1;
  end

  assign DROP_CNT = drop_q;
`else
  assign DROP_CNT = 16'd0;
`endif

endmodule

// File: tb/tb_tmax_scan_ctrl.sv
// Bench for tmax_scan_ctrl: directed stimulus, queued expectations,
// negedge monitor, behavioural max-tracker model.
module tb_tmax_scan_ctrl;
  localparam int W  = 19;
  localparam int SV = 4;

  logic        CLK = 0;
  logic        RESET_N;
  logic [9:0]  T_IN;
  logic [4:0]  T_CH;
  logic        T_VALID, T_READY, RUN;
  logic [W:0]  CH_MASK, CLR_MASK, TM_EN_CPU;
  logic        CLR_REQ, CLR_ACK, RD_REQ, RD_ACK;
  logic [4:0]  RD_CH, TM_NUMBER;
  logic [9:0]  RD_DATA, TM_T, TM_TOUT;
  logic        TM_EN, TM_RESET, BUSY;
  logic [15:0] DROP_CNT;

  tmax_scan_ctrl #(.WIDTH(W), .STARVE(SV)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .T_IN(T_IN), .T_CH(T_CH),
    .T_VALID(T_VALID), .T_READY(T_READY), .RUN(RUN),
    .CH_MASK(CH_MASK), .CLR_REQ(CLR_REQ), .CLR_MASK(CLR_MASK),
    .CLR_ACK(CLR_ACK), .RD_REQ(RD_REQ), .RD_CH(RD_CH),
    .RD_ACK(RD_ACK), .RD_DATA(RD_DATA), .TM_T(TM_T),
    .TM_NUMBER(TM_NUMBER), .TM_EN(TM_EN), .TM_EN_CPU(TM_EN_CPU),
    .TM_RESET(TM_RESET), .TM_TOUT(TM_TOUT), .BUSY(BUSY),
    .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  logic [14:0] en_q[$];
  logic [W:0]  cpu_q[$];
  logic [W:0]  clr_q[$];
  logic [9:0]  rd_q[$];
  logic        prev_rst = 0;
  logic        clr_seen = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic unexp(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  // Max-tracker model: capture on TM_EN, update/clear on TM_EN_CPU.
  logic [9:0] mx[20];
  logic [9:0] lt;
  always @(posedge CLK) begin
    if (!RESET_N) begin
      lt <= 0;
      for (int i = 0; i < 20; i++) mx[i] <= 0;
    end else begin
      if (TM_EN) lt <= TM_T;
      for (int i = 0; i < 20; i++)
        if (TM_EN_CPU[i]) begin
          if (TM_RESET) mx[i] <= 0;
          else if (lt > mx[i]) mx[i] <= lt;
        end
    end
  end
  assign TM_TOUT = (TM_NUMBER >= 5'd1 && TM_NUMBER <= 5'd20)
                   ? mx[TM_NUMBER - 5'd1] : 10'd0;

  // Monitor: pop and compare whenever the DUT shows an event.
  always @(negedge CLK) begin
    if (RESET_N) begin
      if (TM_RESET) begin
        if (clr_q.size() == 0) unexp("clr_unexpected");
        else chk("clr_mask", 32'(TM_EN_CPU), 32'(clr_q.pop_front()));
      end else if (TM_EN_CPU != 0) begin
        if (cpu_q.size() == 0) unexp("cpu_unexpected");
        else chk("upd_onehot", 32'(TM_EN_CPU), 32'(cpu_q.pop_front()));
      end
      if (TM_EN) begin
        if (en_q.size() == 0) unexp("en_unexpected");
        else chk("en_num_t", 32'({TM_NUMBER, TM_T}),
                 32'(en_q.pop_front()));
      end
      if (CLR_ACK) begin
        chk("clr_ack_follows_reset", 32'(prev_rst), 1);
        clr_seen = 1;
      end
      if (RD_ACK) begin
        if (rd_q.size() == 0) unexp("rd_unexpected");
        else chk("rd_data", 32'(RD_DATA), 32'(rd_q.pop_front()));
      end
      prev_rst = TM_RESET;
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #2;
  endtask

  task automatic send(input logic [4:0] ch, input logic [9:0] t,
                      input bit cpu_ev, output int waits);
    logic [31:0] mext;
    bit ev;
    mext = 32'(CH_MASK);
    ev = (ch <= 5'd19) && mext[ch];
    waits = 0;
    T_VALID = 1;
    T_CH = ch;
    T_IN = t;
    #1;
    while (!T_READY && waits < 20) begin
      @(posedge CLK);
      #3;
      waits++;
    end
    if (!T_READY) begin
      chk("send_timeout", 32'(T_READY), 1);
    end else if (ev) begin
      en_q.push_back({ch + 5'd1, t});
      if (cpu_ev) cpu_q.push_back((W+1)'(1) << ch);
    end
    @(posedge CLK);
    #2;
  endtask

  task automatic idle();
    T_VALID = 0;
    cyc();
  endtask

  task automatic do_rd(input logic [4:0] ch, input logic [9:0] exp);
    int n;
    RD_CH = ch;
    RD_REQ = 1;
    rd_q.push_back(exp);
    n = 0;
    #1;
    while (!RD_ACK && n < 20) begin
      @(posedge CLK);
      #3;
      n++;
    end
    chk("rd_ack_seen", 32'(RD_ACK), 1);
    RD_REQ = 0;
    cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int w, w2, w3, n;
    RESET_N = 0; T_IN = 0; T_CH = 0; T_VALID = 0; RUN = 0;
    CH_MASK = 20'hFFFFB; CLR_REQ = 0; CLR_MASK = 0;
    RD_REQ = 0; RD_CH = 0;
    repeat (3) cyc();
    #1;
    chk("rst_t_ready", 32'(T_READY), 0);
    chk("rst_tm", 32'({TM_EN, TM_RESET, TM_NUMBER}), 0);
    chk("rst_en_cpu", 32'(TM_EN_CPU), 0);
    chk("rst_acks", 32'({CLR_ACK, RD_ACK, BUSY}), 0);
    chk("rst_rd_data", 32'(RD_DATA), 0);
    chk("rst_drop", 32'(DROP_CNT), 0);
    #1;
    RESET_N = 1;
    RUN = 1;
    cyc(); cyc();

    send(5'd3, 10'd300, 1, w);
    idle();

    send(5'd5, 10'd11, 1, w);
    send(5'd5, 10'd12, 1, w2);
    send(5'd6, 10'd13, 1, w3);
    idle();
    chk("same_ch_bubble", 32'(w2), 1);
    chk("diff_ch_no_bubble", 32'(w3), 0);

    fork
      begin
        for (int i = 0; i < 14; i++)
          send((i % 2 == 0) ? 5'd10 : 5'd11, 10'(20 + i), 1, w);
        T_VALID = 0;
      end
      begin
        repeat (3) cyc();
        CLR_MASK = 20'hFFFFF;
        CLR_REQ = 1;
        clr_q.push_back(20'hFFFFF);
        n = 0;
        while (n < 20) begin
          @(posedge CLK);
          #3;
          n++;
          if (TM_RESET) break;
        end
        chk("clr_within_starve", 32'(n >= 1 && n <= SV + 2), 1);
        @(posedge CLK);
        #3;
        chk("clr_ack_next", 32'(CLR_ACK), 1);
        CLR_REQ = 0;
      end
    join
    idle(); idle();

    send(5'd7, 10'd100, 1, w);
    send(5'd7, 10'd250, 1, w2);
    idle();
    chk("ch7_bubble", 32'(w2), 1);
    do_rd(5'd7, 10'd250);
    do_rd(5'd25, 10'd0);

    clr_seen = 0;
    CLR_MASK = 20'h00080;
    CLR_REQ = 1;
    RD_CH = 5'd7;
    RD_REQ = 1;
    clr_q.push_back(20'h00080);
    rd_q.push_back(10'd0);
    n = 0;
    #1;
    while (!RD_ACK && n < 20) begin
      @(posedge CLK);
      #3;
      n++;
      if (CLR_ACK) CLR_REQ = 0;
    end
    chk("prio_rd_ack", 32'(RD_ACK), 1);
    chk("prio_clr_first", 32'(clr_seen), 1);
    RD_REQ = 0;
    CLR_REQ = 0;
    cyc();

    send(5'd8, 10'd77, 1, w);
    RUN = 0;
    T_VALID = 1;
    T_CH = 5'd9;
    T_IN = 10'd88;
    #1;
    chk("run_low_no_accept", 32'(T_READY), 0);
    cyc();
    #1;
    chk("run_low_idle", 32'(T_READY), 0);
    T_VALID = 0;
    RUN = 1;
    cyc(); cyc();

    send(5'd4, 10'd500, 0, w);
    RESET_N = 0;
    #1;
    chk("mid_rst_en_cpu", 32'(TM_EN_CPU), 0);
    chk("mid_rst_busy", 32'(BUSY), 0);
    T_VALID = 0;
    cyc(); cyc();
    RESET_N = 1;
    cyc(); cyc();

    send(5'd2, 10'd1, 1, w);
    send(5'd2, 10'd2, 1, w);
    send(5'd25, 10'd3, 1, w);
    idle(); idle();
`ifdef TMAX_SCAN_DROP_CNT_EN
    chk("drop_cnt", 32'(DROP_CNT), 3);
`else
    chk("drop_cnt", 32'(DROP_CNT), 0);
`endif

    chk("en_q_drained", en_q.size(), 0);
    chk("cpu_q_drained", cpu_q.size(), 0);
    chk("clr_q_drained", clr_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tmax_scan_ctrl.md
TMAX_SCAN_CTRL -- requirements
Module: tmax_scan_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 19, the highest channel index (channels 0..WIDTH).
REQ-002 SHALL have parameter STARVE, default 4, the maximum number of cycles a pending clear or read waits behind the sample stream.
REQ-003 SHALL have port CLK  in  1  the single clock; all logic is on the rising edge.
REQ-004 SHALL have port RESET_N  in  1  asynchronous active-low reset.
REQ-005 SHALL have port T_IN  in  10  temperature sample.
REQ-006 SHALL have port T_CH  in  5  channel tag of the sample.
REQ-007 SHALL have port T_VALID  in  1  sample valid.
REQ-008 SHALL have port T_READY  out  1  sample accepted when T_VALID && T_READY.
REQ-009 SHALL have port RUN  in  1  stream enable level.
REQ-010 SHALL have port CH_MASK  in  WIDTH+1  per-channel tracking enable.
REQ-011 SHALL have port CLR_REQ  in  1  clear request level, held until CLR_ACK.
REQ-012 SHALL have port CLR_MASK  in  WIDTH+1  channels to clear.
REQ-013 SHALL have port CLR_ACK  out  1  one-cycle clear-done pulse.
REQ-014 SHALL have port RD_REQ  in  1  read request level, held until RD_ACK.
REQ-015 SHALL have port RD_CH  in  5  channel to read.
REQ-016 SHALL have port RD_ACK  out  1  one-cycle read-done pulse.
REQ-017 SHALL have port RD_DATA  out  10  registered maximum of RD_CH.
REQ-018 SHALL have ports TM_T out 10, TM_NUMBER out 5, TM_EN out 1, TM_EN_CPU out WIDTH+1, TM_RESET out 1, and TM_TOUT in 10, which drive and read the per-channel max tracker.
REQ-019 SHALL have port BUSY  out  1  high when an update phase, clear or read is in progress.
REQ-020 SHALL have port DROP_CNT  out  16  count of dropped samples.

Function
REQ-021 SHALL implement an FSM with states IDLE, STREAM, CLR and RD; IDLE moves to STREAM when RUN=1; STREAM moves to IDLE when RUN=0 and nothing is pending; CLR and RD last one cycle each and then return to STREAM or IDLE.
REQ-022 SHALL, in the accept cycle k of a sample with T_CH<=WIDTH and CH_MASK[T_CH]=1, drive TM_T=T_IN, TM_NUMBER=T_CH+1 and TM_EN=1.
REQ-023 SHALL, in cycle k+1 (the update phase), drive TM_EN_CPU one-hot at bit T_CH.
REQ-024 SHALL consume a sample with an out-of-range or masked tag without asserting TM_EN or TM_EN_CPU, and count it as dropped.
REQ-025 SHALL deassert T_READY in cycle k+1 when the T_CH presented in k+1 equals the channel accepted in k (read-after-update hazard bubble).
REQ-026 SHALL deassert T_READY in IDLE, in CLR, in RD, and in the cycle after STARVE consecutive cycles with a request pending.
REQ-027 SHALL drive TM_NUMBER=0, TM_EN=0, TM_EN_CPU=0 and TM_RESET=0 when no operation is active.
REQ-028 SHALL execute a clear in the first cycle that has no update phase, driving TM_RESET=1 and TM_EN_CPU=CLR_MASK for that one cycle, then pulse CLR_ACK in the following cycle.
REQ-029 SHALL execute a read only in a cycle with no update phase and no clear, driving TM_NUMBER=RD_CH+1 and TM_EN=0, registering RD_DATA from TM_TOUT, and pulsing RD_ACK in the next cycle.
REQ-030 SHALL return RD_DATA=0 when RD_CH>WIDTH.
REQ-031 SHALL give a clear priority over a read when both are pending in the same cycle.
REQ-032 SHALL complete an in-flight update phase when RUN falls, but accept no new sample.

Reset
REQ-033 SHALL, while RESET_N=0, force the state to IDLE and all outputs, counters and pending flags to 0, asynchronously.
REQ-034 SHALL discard any in-flight update or request when reset is asserted mid-operation; requesters re-execute by continuing to hold their request level.

Configuration
REQ-035 SHALL, with TMAX_SCAN_DROP_CNT_EN defined, increment DROP_CNT by 1 per dropped sample, saturating at 16'hFFFF.
REQ-036 SHALL, with TMAX_SCAN_DROP_CNT_EN undefined, tie DROP_CNT to 0 and contain no counter logic.

Verification
REQ-037 Sample T_CH=3, T_IN=300 accepted at cycle k -> TM_NUMBER=4 and TM_EN=1 at k; TM_EN_CPU=20'h00008 at k+1.
REQ-038 Back-to-back samples T_CH=5 -> T_READY=0 for one cycle; a T_CH=6 sample following a T_CH=5 sample -> no bubble.
REQ-039 CLR_REQ with CLR_MASK=20'hFFFFF during continuous streaming -> TM_RESET pulse within STARVE+2 cycles and CLR_ACK on the next cycle.
REQ-040 After samples 100 then 250 on channel 7, RD_CH=7 -> RD_DATA=250 with an RD_ACK pulse; RD_CH=25 -> RD_DATA=0.
REQ-041 RESET_N low in an update phase -> TM_EN_CPU=0 immediately; with the macro defined, 3 masked samples -> DROP_CNT=3.
